// File: rtl/sr_setup_bank_pkg.sv
// sr_setup_bank_pkg: shared conflict encodings, clear-FSM states and counter helper
package sr_setup_bank_pkg;
    localparam int RESET_DOM = 0;
    localparam int SET_DOM   = 1;
    localparam int HOLD      = 2;
    localparam int TOGGLE    = 3;
    typedef enum logic [1:0] {IDLE, CLEAR, ACK} clr_state_t;
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v >= max) ? max : v + 64'd1;
    endfunction
endpackage

// File: rtl/sr_setup_bank_cell.sv
// sr_cell_next: next value of one S/R cell, force0 overriding the set/reset decode
module sr_cell_next
    import sr_setup_bank_pkg::*;
#(
    parameter int CONFLICT_MODE = RESET_DOM
) (
    input  logic s,
    input  logic r,
    input  logic q,
    input  logic force0,
    output logic q_next
);
    logic conflict_val;
    assign conflict_val = (CONFLICT_MODE == SET_DOM) ? 1'b1 :
                          (CONFLICT_MODE == HOLD)    ? q    :
                          (CONFLICT_MODE == TOGGLE)  ? ~q   : 1'b0;
    assign q_next = force0 ? 1'b0 : (s && r) ? conflict_val : s ? 1'b1 : r ? 1'b0 : q;
endmodule

// File: rtl/sr_setup_bank.sv
// sr_setup_bank: bank of S/R cells with force-clear, handshaked sequenced clear and conflict stats
module sr_setup_bank
    import sr_setup_bank_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int CONFLICT_MODE = 0,
    parameter int CLR_SWEEP     = 1,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] s,
    input  logic [CHANNELS-1:0] r,
    input  logic                is0,
    input  logic                clr_req,
    output logic                clr_ack,
    output logic                busy,
    output logic [CHANNELS-1:0] q,
    output logic                q_changed,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    conflict_cnt,
    output logic                conflict_flag
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);
    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

    clr_state_t state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CHANNELS-1:0] target, s_g, r_g, q_next;
    logic conflict;

    // busy mirrors the CLEAR state, so it gates s/r and selects the cleared channel(s)
    assign target = (CLR_SWEEP != 0) ? (CHANNELS'(1) << idx) : '1;
    assign s_g = busy ? '0 : s;
    assign r_g = busy ? '0 : r;
    assign conflict = !is0 && !busy && |(s & r);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cell
        sr_cell_next #(.CONFLICT_MODE(CONFLICT_MODE)) u_cell (
            .s     (s_g[g]),
            .r     (r_g[g]),
            .q     (q[g]),
            .force0(is0 || (busy && target[g])),
            .q_next(q_next[g])
        );
    end

    // clear sequencer: accept request in IDLE, sweep (or clear at once), then hold ack
    always_comb begin
        state_next = state;
        idx_next = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    idx_next = '0;
                end
            end
            CLEAR: begin
                if (is0 || CLR_SWEEP == 0 || idx == LAST) state_next = ACK;
                else idx_next = idx + 1'b1;
            end
            ACK: state_next = clr_req ? ACK : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cell storage, change detect and registered FSM-derived outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            q <= '0;
            q_changed <= 1'b0;
            busy <= 1'b0;
            clr_ack <= 1'b0;
        end else begin
            state <= state_next;
            idx <= idx_next;
            q <= q_next;
            q_changed <= q_next != q;
            busy <= state_next == CLEAR;
            clr_ack <= state_next == ACK;
        end
    end

    // saturating conflict counter and sticky flag; clear beats a simultaneous conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            conflict_flag <= 1'b0;
        end else if (cnt_clr) begin
            conflict_cnt <= '0;
            conflict_flag <= 1'b0;
        end else if (conflict) begin
            conflict_cnt <= CNT_W'(sat_inc(64'(conflict_cnt), CNT_MAX));
            conflict_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sr_setup_bank.sv
// tb_sr_setup_bank: scoreboard bench over all conflict modes plus an all-at-once clear variant
module tb_sr_setup_bank;
    localparam int N = 5;
    typedef struct {
        int q;
        bit qc;
        bit ack;
        bit busy;
        int cnt;
        bit flag;
    } exp_t;

    logic clk = 0, rst_n = 0;
    logic [7:0] s = 0, r = 0;
    logic is0 = 0, clr_req = 0, cnt_clr = 0;
    logic [7:0] q_o [N];
    logic [2:0] cnt_o [N];
    logic ack_o [N], busy_o [N], qc_o [N], flag_o [N];

    int n_vec = 0, n_err = 0;
    int mq [N], ph [N], pos [N], mcnt [N];
    bit mflag [N];
    exp_t sb [N][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sr_setup_bank #(
            .CHANNELS(8), .CONFLICT_MODE(g < 4 ? g : 3), .CLR_SWEEP(g < 4 ? 1 : 0), .CNT_W(3)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .s(s), .r(r), .is0(is0), .clr_req(clr_req),
            .clr_ack(ack_o[g]), .busy(busy_o[g]), .q(q_o[g]), .q_changed(qc_o[g]),
            .cnt_clr(cnt_clr), .conflict_cnt(cnt_o[g]), .conflict_flag(flag_o[g])
        );
    end

    function automatic void check(string name, int g, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
        end
    endfunction

    // one cycle of stimulus; the reference model predicts every instance's registered outputs
    task automatic step(input logic [7:0] si, input logic [7:0] ri, input bit i0, input bit cr,
                        input bit cc, input bit rn = 1);
        @(negedge clk);
        s = si; r = ri; is0 = i0; clr_req = cr; cnt_clr = cc; rst_n = rn;
        if (!rn) begin
            #1;
            for (int g = 0; g < N; g++) begin
                check("async_q", g, q_o[g], 0);
                check("async_busy", g, busy_o[g], 0);
                check("async_ack", g, ack_o[g], 0);
                check("async_qc", g, qc_o[g], 0);
                check("async_cnt", g, cnt_o[g], 0);
                check("async_flag", g, flag_o[g], 0);
            end
        end
        for (int g = 0; g < N; g++) begin
            int m, nq;
            bit sw, in_clear, conf, nb;
            exp_t e;
            m = g < 4 ? g : 3;
            sw = g < 4;
            if (!rn) begin
                mq[g] = 0; ph[g] = 0; pos[g] = 0; mcnt[g] = 0; mflag[g] = 0;
                e = '{0, 0, 0, 0, 0, 0};
            end else begin
                in_clear = ph[g] == 1;
                conf = !i0 && !in_clear && (si & ri) != 0;
                nq = mq[g];
                if (i0) nq = 0;
                else if (in_clear) nq = sw ? (mq[g] & ~(1 << pos[g])) : 0;
                else for (int b = 0; b < 8; b++) begin
                    if (si[b] && ri[b]) nb = (m == 0) ? 1'b0 : (m == 1) ? 1'b1 : (m == 2) ? mq[g][b] : !mq[g][b];
                    else if (si[b]) nb = 1;
                    else if (ri[b]) nb = 0;
                    else nb = mq[g][b];
                    nq[b] = nb;
                end
                if (cc) begin
                    mcnt[g] = 0; mflag[g] = 0;
                end else if (conf) begin
                    mcnt[g] = mcnt[g] < 7 ? mcnt[g] + 1 : 7; mflag[g] = 1;
                end
                if (ph[g] == 0) begin
                    if (cr) begin ph[g] = 1; pos[g] = 0; end
                end else if (ph[g] == 1) begin
                    if (i0 || !sw || pos[g] == 7) ph[g] = 2;
                    else pos[g]++;
                end else if (!cr) ph[g] = 0;
                e.qc = nq != mq[g];
                mq[g] = nq;
                e.q = nq; e.ack = ph[g] == 2; e.busy = ph[g] == 1; e.cnt = mcnt[g]; e.flag = mflag[g];
            end
            sb[g].push_back(e);
        end
    endtask

    // monitor: after each edge pop the prediction for that edge and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int g = 0; g < N; g++) if (sb[g].size() > 0) begin
                e = sb[g].pop_front();
                check("q", g, q_o[g], e.q);
                check("q_changed", g, qc_o[g], e.qc);
                check("clr_ack", g, ack_o[g], e.ack);
                check("busy", g, busy_o[g], e.busy);
                check("conflict_cnt", g, cnt_o[g], e.cnt);
                check("conflict_flag", g, flag_o[g], e.flag);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] conf_q [N];
        bit cr;
        conf_q = '{8'h0C, 8'h0F, 8'h0F, 8'h0C, 8'h0C};
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(8'hA5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(8'h0F, 8'hF0, 0, 0, 1);
        step(8'h03, 8'h03, 0, 0, 0);
        @(posedge clk);
        #2;
        for (int g = 0; g < N; g++) begin
            check("mode_conflict_q", g, q_o[g], conf_q[g]);
            check("mode_conflict_cnt", g, cnt_o[g], 1);
            check("mode_conflict_flag", g, flag_o[g], 1);
        end
        step(8'hFF, 0, 0, 0, 0);
        step(8'hFF, 0, 0, 1, 0);
        repeat (11) step(8'hFF, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(8'hFF, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (9) step(8'h01, 8'h01, 0, 0, 0);
        step(8'h01, 8'h01, 0, 0, 1);
        step(8'hFF, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(8'hFF, 0, 0, 0, 0);
        repeat (12) step(8'h0F, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        cr = 0;
        repeat (600) begin
            if ($urandom_range(0, 7) == 0) cr = !cr;
            step($urandom, $urandom, $urandom_range(0, 15) == 0, cr, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 199) != 0);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        for (int g = 0; g < N; g++) check("sb_drain", g, sb[g].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
